// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg: shared FSM encoding, switch width and default timing constants
package detector_jogada_pkg;
    localparam int N_CHAVES        = 4;
    localparam int DEBOUNCE_PADRAO = 4;
    localparam int TIMEOUT_PADRAO  = 5000;
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ESPERA_ZERO = 3'd1,
        AGUARDA     = 3'd2,
        FILTRA      = 3'd3,
        REGISTRA    = 3'd4,
        ESGOTADO    = 3'd5
    } estado_t;
endpackage

// File: rtl/detector_jogada_if.sv
// detector_jogada_if: control, push-button and play-report signals of the play detector
interface detector_jogada_if;
    import detector_jogada_pkg::*;
    logic                habilita;
    logic                limpa;
    logic [N_CHAVES-1:0] chaves;
    logic [N_CHAVES-1:0] jogada;
    logic                tem_jogada;
    logic                jogada_invalida;
    logic                timeout;
    logic [2:0]          db_estado;
    modport master (output habilita, limpa, chaves,
                    input  jogada, tem_jogada, jogada_invalida, timeout, db_estado);
    modport slave  (input  habilita, limpa, chaves,
                    output jogada, tem_jogada, jogada_invalida, timeout, db_estado);
endinterface

// File: rtl/detector_jogada_sincronizador.sv
// sincronizador_2ff: two-flop synchronizer for asynchronous level inputs
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);
    logic [LARGURA-1:0] meta_q, sync_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    assign q_o = sync_q;
endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: debounces the push buttons and reports one-hot plays as single-cycle pulses.
// Define DETECTOR_JOGADA_TIMEOUT_EN to add the idle-wait timeout (state ESGOTADO).
module detector_jogada import detector_jogada_pkg::*; #(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int TIMEOUT_CICLOS  = TIMEOUT_PADRAO
) (
    input logic              clock,
    input logic              reset,
    detector_jogada_if.slave io
);
    localparam int DW = $clog2(DEBOUNCE_CICLOS);
    if (DEBOUNCE_CICLOS < 2 || TIMEOUT_CICLOS < 1) begin : g_param_invalido
        $error("detector_jogada: DEBOUNCE_CICLOS >= 2 and TIMEOUT_CICLOS >= 1 required");
    end
    estado_t             estado_q, estado_d;
    logic [N_CHAVES-1:0] sync, amostra_q, amostra_d, jogada_q, jogada_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic                tem_q, tem_d, inv_q, inv_d;
    sincronizador_2ff #(.LARGURA(N_CHAVES)) u_sync (
        .clock(clock),
        .reset(reset),
        .d_i  (io.chaves),
        .q_o  (sync)
    );
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif
    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        amostra_d = amostra_q;
        tem_d     = 1'b0;
        inv_d     = 1'b0;
        jogada_d  = io.limpa ? '0 : jogada_q;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
        tcnt_d    = '0;
        tmo_d     = 1'b0;
`endif
        if (!io.habilita) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
        end else case (estado_q)
            OCIOSO: begin
                estado_d = ESPERA_ZERO;
                cnt_d    = '0;
            end
            ESPERA_ZERO: begin
                cnt_d = (sync != '0) ? '0 : cnt_q + DW'(1);
                if (sync == '0 && cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                    estado_d = AGUARDA;
                    cnt_d    = '0;
                end
            end
            AGUARDA: begin
                if (sync != '0) begin
                    amostra_d = sync;
                    cnt_d     = '0;
                    estado_d  = FILTRA;
                end
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    estado_d = ESGOTADO;
                    tmo_d    = 1'b1;
                end else tcnt_d = tcnt_q + TW'(1);
`endif
            end
            FILTRA: begin
                if (sync == '0) begin
                    estado_d = AGUARDA;
                    cnt_d    = '0;
                end else if (sync != amostra_q) begin
                    amostra_d = sync;
                    cnt_d     = '0;
                end else if (cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                    estado_d = REGISTRA;
                    cnt_d    = '0;
                end else cnt_d = cnt_q + DW'(1);
            end
            REGISTRA: begin
                // a valid capture overrides a simultaneous limpa
                estado_d = ESPERA_ZERO;
                if ($onehot(amostra_q)) begin
                    jogada_d = amostra_q;
                    tem_d    = 1'b1;
                end else inv_d = 1'b1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            amostra_q <= '0;
            jogada_q  <= '0;
            tem_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            amostra_q <= amostra_d;
            jogada_q  <= jogada_d;
            tem_q     <= tem_d;
            inv_q     <= inv_d;
        end
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    assign io.timeout = tmo_q;
`else
    assign io.timeout = 1'b0;
`endif
    assign io.jogada          = jogada_q;
    assign io.tem_jogada      = tem_q;
    assign io.jogada_invalida = inv_q;
    assign io.db_estado       = estado_q;
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: randomized play stimulus scored against a run-based reference model
module tb_detector_jogada;
    import detector_jogada_pkg::*;
    localparam int D  = 4;
    localparam int T  = 20;
    localparam int NE = 8192;
    localparam int F_IDLE = 0, F_ARM = 1, F_WAIT = 2, F_FILT = 3, F_REG = 4, F_DEAD = 5;
    logic clock = 1'b0;
    logic reset = 1'b1;
    detector_jogada_if io();
    detector_jogada #(.DEBOUNCE_CICLOS(D), .TIMEOUT_CICLOS(T)) dut (
        .clock(clock),
        .reset(reset),
        .io   (io)
    );
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;
    typedef struct {
        logic [2:0] tipo;
        int         borda;
        logic [3:0] jog;
    } ev_t;
    ev_t fila[$];
    logic [3:0] c_hist[NE];
    logic [2:0] fase_hist[NE];
    bit         vld[NE];
    int         fase, z, w, run, ultima_borda, ultimo_tem;
    logic [3:0] val, jog_m;
    int checks = 0, fails = 0, n_tem = 0, n_inv = 0, n_tmo = 0;
    // Reference: each edge e decides on the button value applied two edges earlier.
    task automatic modelo(input int e, input logic h, input logic l);
        logic [3:0] x;
        x = c_hist[e-2];
        if (l) jog_m = 4'b0;
        if (!h) fase = F_IDLE;
        else case (fase)
            F_IDLE: begin fase = F_ARM; z = 0; end
            F_ARM: begin
                z = (x == 0) ? z + 1 : 0;
                if (z == D) begin fase = F_WAIT; w = 0; end
            end
            F_WAIT: begin
                if (x != 0) begin val = x; run = 1; fase = F_FILT; end
                else begin
                    w++;
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
                    if (w == T) begin fila.push_back('{3'b100, e, jog_m}); fase = F_DEAD; end
`endif
                end
            end
            F_FILT: begin
                if (x == 0) begin fase = F_WAIT; w = 0; end
                else if (x != val) begin val = x; run = 1; end
                else begin run++; if (run == D + 1) fase = F_REG; end
            end
            F_REG: begin
                if ($countones(val) == 1) begin
                    jog_m = val;
                    fila.push_back('{3'b001, e, val});
                end else fila.push_back('{3'b010, e, jog_m});
                fase = F_ARM;
                z = 0;
            end
            default: ;
        endcase
        fase_hist[e] = 3'(fase);
        vld[e] = 1'b1;
    endtask
    task automatic passo(input logic [3:0] v, input logic h, input logic l);
        @(negedge clock);
        io.chaves = v;
        io.habilita = h;
        io.limpa = l;
        ultima_borda = cyc + 1;
        c_hist[cyc+1] = v;
        modelo(cyc + 1, h, l);
    endtask
    task automatic segura(input logic [3:0] v, input int n);
        repeat (n) passo(v, 1'b1, 1'b0);
    endtask
    task automatic verifica(input string nome, input int obtido, input int esperado);
        checks++;
        if (obtido != esperado) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", nome, obtido, esperado);
        end
    endtask
    task automatic aplica_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        io.chaves = 4'b0;
        io.habilita = 1'b0;
        io.limpa = 1'b0;
        #1;
        verifica("reset_jogada", int'(io.jogada), 0);
        verifica("reset_estado", int'(io.db_estado), 0);
        verifica("reset_pulsos", int'({io.timeout, io.jogada_invalida, io.tem_jogada}), 0);
        fase = F_IDLE;
        jog_m = 4'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = cyc - 2; i <= cyc + 2; i++) c_hist[i] = 4'b0;
    endtask
    always @(negedge clock) begin
        ev_t ex;
        if (cyc < NE && vld[cyc]) begin
            checks++;
            if (io.db_estado !== fase_hist[cyc]) begin
                fails++;
                $display("FAIL db_estado edge=%0d got=%0d expected=%0d", cyc, io.db_estado, fase_hist[cyc]);
            end
        end
        if (io.tem_jogada || io.jogada_invalida || io.timeout) begin
            checks++;
            n_tem += int'(io.tem_jogada);
            n_inv += int'(io.jogada_invalida);
            n_tmo += int'(io.timeout);
            if (io.tem_jogada) ultimo_tem = cyc;
            if (fila.size() == 0) begin
                fails++;
                $display("FAIL pulso_inesperado edge=%0d pulses(tmo,inv,tem)=%b", cyc,
                         {io.timeout, io.jogada_invalida, io.tem_jogada});
            end else begin
                ex = fila.pop_front();
                if ({io.timeout, io.jogada_invalida, io.tem_jogada} !== ex.tipo || cyc != ex.borda
                    || io.jogada !== ex.jog) begin
                    fails++;
                    $display("FAIL evento got pulses=%b edge=%0d jogada=%b expected pulses=%b edge=%0d jogada=%b",
                             {io.timeout, io.jogada_invalida, io.tem_jogada}, cyc, io.jogada,
                             ex.tipo, ex.borda, ex.jog);
                end
            end
        end
    end
    initial begin
        int t0, i0, e0, r, n;
        logic [3:0] v;
        logic h;
        io.chaves = 4'b0;
        io.habilita = 1'b0;
        io.limpa = 1'b0;
        fase = F_IDLE;
        jog_m = 4'b0;
        #1 reset = 1'b0;
        aplica_reset();
        segura(4'b0000, 8);
        t0 = n_tem;
        passo(4'b0001, 1'b1, 1'b0);
        e0 = ultima_borda;
        segura(4'b0001, 9);
        segura(4'b0000, 6);
        verifica("latencia_tem", ultimo_tem - e0, D + 3);
        verifica("pulsos_0001", n_tem - t0, 1);
        verifica("jogada_0001", int'(io.jogada), 1);
        t0 = n_tem;
        segura(4'b0010, 2);
        segura(4'b0000, 8);
        verifica("estado_curto", int'(io.db_estado), 2);
        verifica("pulsos_curto", n_tem - t0, 0);
        verifica("jogada_curto", int'(io.jogada), 1);
        t0 = n_tem;
        i0 = n_inv;
        segura(4'b0101, 10);
        segura(4'b0000, 8);
        verifica("invalida_pulsos", n_inv - i0, 1);
        verifica("invalida_tem", n_tem - t0, 0);
        verifica("invalida_jogada", int'(io.jogada), 1);
        t0 = n_tem;
        segura(4'b1000, 30);
        segura(4'b0000, 8);
        segura(4'b0100, 10);
        segura(4'b0000, 8);
        verifica("segurado_pulsos", n_tem - t0, 2);
        verifica("segurado_jogada", int'(io.jogada), 4);
        t0 = n_tem;
        segura(4'b0001, 4);
        aplica_reset();
        segura(4'b0000, 12);
        verifica("pos_reset_pulsos", n_tem - t0, 0);
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
        i0 = n_tmo;
        segura(4'b0000, 40);
        verifica("timeout_pulsos", n_tmo - i0, 1);
        verifica("timeout_estado", int'(io.db_estado), 5);
        passo(4'b0000, 1'b0, 1'b0);
        @(negedge clock);
        verifica("timeout_sai", int'(io.db_estado), 0);
`endif
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            n = $urandom_range(1, 10);
            h = ($urandom_range(0, 19) != 0);
            v = (r < 4) ? 4'b0 : (r < 8) ? (4'b0001 << (r - 4)) : 4'($urandom);
            for (int k = 0; k < n; k++) passo(v, h, $urandom_range(0, 19) == 0);
        end
        segura(4'b0000, 15);
        @(negedge clock);
        #1;
        verifica("fila_vazia", fila.size(), 0);
        verifica("jogada_final", int'(io.jogada), int'(jog_m));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
